apb_i2c_master_arb: RTL

Two-port APB master that shares the APB-to-I2C bridge slave between two on-chip requesters, such as a config loader and a data mover. It arbitrates round-robin, sequences each command through the APB SETUP/ACCESS phases, and returns read data and error status to the winning requester. An optional watchdog aborts transfers that never see PREADY, which happens when the bridge is given an illegal address/direction combination.

---
 rtl/apb_i2c_pkg.sv | 40 ++++
 rtl/rr_arb2.sv | 31 +++
 rtl/apb_i2c_master_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB-to-I2C bridge master arbiter: register map,
// FSM state encoding and the latched command record.
package apb_i2c_pkg;

    localparam logic [1:0] SEL_TX      = 2'd0;
    localparam logic [1:0] SEL_RX      = 2'd1;
    localparam logic [1:0] SEL_CONFIG  = 2'd2;
    localparam logic [1:0] SEL_TIMEOUT = 2'd3;

    localparam logic [31:0] OFF_TX      = 32'h0000_0000;
    localparam logic [31:0] OFF_RX      = 32'h0000_0004;
    localparam logic [31:0] OFF_CONFIG  = 32'h0000_0008;
    localparam logic [31:0] OFF_TIMEOUT = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } apb_cmd_t;

    function automatic logic [31:0] sel_to_paddr(input logic [1:0] sel);
        logic [31:0] paddr;
        case (sel)
            SEL_TX:      paddr = OFF_TX;
            SEL_RX:      paddr = OFF_RX;
            SEL_CONFIG:  paddr = OFF_CONFIG;
            SEL_TIMEOUT: paddr = OFF_TIMEOUT;
            default:     paddr = '0;
        endcase
        return paddr;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on contention the
// requester that was not granted last wins.
module rr_arb2 (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer resets to 1 so that requester 0 wins the first contended grant.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            last <= 1'b1;
        end else if (advance && (|grant)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/apb_i2c_master_arb.sv
// Two-requester APB master sharing the APB-to-I2C bridge slave.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_i2c_master_arb
    import apb_i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_write,
    input  logic [1:0][1:0]  req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       req_ready,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic             PSELx,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [31:0]      PADDR,
    output logic [31:0]      PWDATA,
    input  logic [31:0]      PRDATA,
    input  logic             PREADY,
    input  logic             PSLVERR
);

    apb_state_t  state;
    apb_state_t  state_next;
    apb_cmd_t    cmd;
    logic [1:0]  grant;
    logic        last_ptr;
    logic        accept;
    logic        complete;
    logic        timeout_hit;
    logic        bus_on;
    logic [31:0] rdata_q;
    logic        err_q;

    // A TIMEOUT_CYC below 1 is not a legal configuration.
    if (TIMEOUT_CYC < 1) begin : g_illegal_timeout_cfg
    end

    assign accept   = (state == ST_IDLE) && (|req_valid) && !PRESET;
    assign complete = (state == ST_ACCESS) && PREADY;

    // The pointer equals the granted index for the whole transfer after accept.
    rr_arb2 u_arb (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant),
        .last    (last_ptr)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts stalled ACCESS cycles; saturates instead of wrapping.
    always_ff @(posedge PCLK) begin
        if (PRESET || accept) begin
            tmo_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY && (tmo_cnt != CNT_MAX)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // A PREADY arriving on the limit cycle wins over the abort.
    assign timeout_hit = (state == ST_ACCESS) && !PREADY && (tmo_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            cmd     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cmd <= {req_write[grant[1]], req_addr[grant[1]], req_wdata[grant[1]]};
            end
            if (complete) begin
                rdata_q <= cmd.write ? 32'h0 : PRDATA;
                err_q   <= PSLVERR;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        busy       = (state != ST_IDLE);
        bus_on     = (state == ST_SETUP) || (state == ST_ACCESS);
        PSELx      = bus_on;
        PENABLE    = (state == ST_ACCESS);
        PWRITE     = bus_on && cmd.write;
        PADDR      = bus_on ? sel_to_paddr(cmd.addr) : 32'h0;
        PWDATA     = (bus_on && cmd.write) ? cmd.wdata : 32'h0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    req_ready  = grant;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (complete || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid  = last_ptr ? 2'b10 : 2'b01;
                rsp_rdata  = rdata_q;
                rsp_err    = err_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
